// File: rtl/movegen_arb_pkg.sv
// rtl/movegen_arb_pkg.sv - shared types and helpers for the move-generator SDRAM arbiter
package movegen_arb_pkg;

    localparam int N_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RD_WAIT,
        RELEASE
    } arb_state_t;

    // Grants never exceed 8 requesters, so a fixed 8-bit view covers every build.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/movegen_mem_arbiter_rr_pick.sv
// rtl/movegen_mem_arbiter_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick
    import movegen_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] active,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] onehot,
    output logic             any
);

    int j;

    // First active requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        onehot = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!any && active[j]) begin
                onehot[j] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/movegen_mem_arbiter.sv
// rtl/movegen_mem_arbiter.sv - round-robin SDRAM Avalon-MM arbiter for move-gen engines
// Optional grant hold across transactions via ARB_LOCK_EN.
module movegen_mem_arbiter
    import movegen_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*AW-1:0] req_address,
    input  logic [N_REQ-1:0]    req_read,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [N_REQ*DW-1:0] req_writedata,
    input  logic [N_REQ-1:0]    req_lock,
    output logic [N_REQ-1:0]    req_waitrequest,
    output logic [DW-1:0]       req_readdata,
    output logic [N_REQ-1:0]    req_readdatavalid,
    input  logic                master_waitrequest,
    output logic [AW-1:0]       master_address,
    output logic                master_read,
    output logic                master_write,
    output logic [DW-1:0]       master_writedata,
    input  logic [DW-1:0]       master_readdata,
    input  logic                master_readdatavalid,
    output logic [N_REQ-1:0]    grant,
    output logic                err_spurious
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    next_ptr;
    logic [2:0]       g_idx;
    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_any;

    logic [AW-1:0]    g_address;
    logic [DW-1:0]    g_writedata;
    logic             g_read;
    logic             g_write;
    logic             g_lock;
    logic             lock_hold;

    assign active = req_read | req_write;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .active (active),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    // Grant is one-hot, so OR-ing masked slices acts as the owner mux.
    always_comb begin
        g_address   = '0;
        g_writedata = '0;
        g_read      = 1'b0;
        g_write     = 1'b0;
        g_lock      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_address   = g_address   | req_address[i*AW +: AW];
                g_writedata = g_writedata | req_writedata[i*DW +: DW];
                g_read      = g_read      | req_read[i];
                g_write     = g_write     | req_write[i];
                g_lock      = g_lock      | req_lock[i];
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign lock_hold = g_lock;
`else
    assign lock_hold = g_lock & 1'b0;
`endif

    always_comb begin
        g_idx    = onehot_to_idx(8'(grant));
        next_ptr = (g_idx == 3'(N_REQ - 1)) ? '0 : PW'(g_idx + 3'd1);
    end

    // A read-and-write requester is served as a read.
    always_comb begin
        master_address    = '0;
        master_writedata  = '0;
        master_read       = 1'b0;
        master_write      = 1'b0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        if (state == XFER) begin
            master_address   = g_address;
            master_writedata = g_writedata;
            master_read      = g_read;
            master_write     = g_write & ~g_read;
            req_waitrequest  = ~grant | {N_REQ{master_waitrequest}};
        end
        if (state == RD_WAIT && master_readdatavalid) begin
            req_readdatavalid = grant;
        end
    end

    assign req_readdata = master_readdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (master_readdatavalid && state != RD_WAIT) begin
                err_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_onehot;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (!(g_read | g_write)) begin
                        state <= RELEASE;
                    end else if (!master_waitrequest) begin
                        state <= g_read ? RD_WAIT : RELEASE;
                    end
                end
                RD_WAIT: begin
                    if (master_readdatavalid) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (lock_hold) begin
                        state <= XFER;
                    end else begin
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_movegen_mem_arbiter.sv
// tb/tb_movegen_mem_arbiter.sv - directed self-checking bench for movegen_mem_arbiter
module tb_movegen_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_writedata;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [N-1:0]    req_readdatavalid;
    logic            master_waitrequest;
    logic [AW-1:0]   master_address;
    logic            master_read;
    logic            master_write;
    logic [DW-1:0]   master_writedata;
    logic [DW-1:0]   master_readdata;
    logic            master_readdatavalid;
    logic [N-1:0]    grant;
    logic            err_spurious;

    int checks   = 0;
    int failures = 0;
    int exp_rr [6] = '{0, 1, 3, 0, 1, 3};

    movegen_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_address          (req_address),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_writedata        (req_writedata),
        .req_lock             (req_lock),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .grant                (grant),
        .err_spurious         (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int owner_idx(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic clear_inputs;
        req_address          = '0;
        req_read             = '0;
        req_write            = '0;
        req_writedata        = '0;
        req_lock             = '0;
        master_waitrequest   = 1'b0;
        master_readdata      = '0;
        master_readdatavalid = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
        checks++; if (master_read !== 1'b0 || master_write !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", master_read, master_write); end
        checks++; if (master_address !== 32'h0 || master_writedata !== 32'h0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", master_address, master_writedata); end
        checks++; if (req_waitrequest !== 4'hF) begin failures++; $display("FAIL reset_waitreq got=%b exp=%b", req_waitrequest, 4'hF); end
        checks++; if (req_readdatavalid !== 4'b0000 || err_spurious !== 1'b0) begin failures++; $display("FAIL reset_rdv_err got=%b/%b exp=0000/0", req_readdatavalid, err_spurious); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        apply_reset();
        req_address[0 +: AW] = 32'h100;
        req_read             = 4'b0001;
        master_waitrequest   = 1'b1;
        next_cycle(); #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rd_grant got=%b exp=%b", grant, 4'b0001); end
        checks++; if (master_read !== 1'b1 || master_address !== 32'h100) begin failures++; $display("FAIL rd_master got=%b/%h exp=1/100", master_read, master_address); end
        checks++; if (req_waitrequest !== 4'hF) begin failures++; $display("FAIL rd_wait_held got=%b exp=%b", req_waitrequest, 4'hF); end
        next_cycle();
        master_waitrequest = 1'b0;
        #1;
        checks++; if (req_waitrequest !== 4'b1110 || master_read !== 1'b1) begin failures++; $display("FAIL rd_accept got=%b/%b exp=1110/1", req_waitrequest, master_read); end
        next_cycle();
        req_read           = 4'b0000;
        master_waitrequest = 1'b1;
        #1;
        checks++; if (master_read !== 1'b0 || req_waitrequest !== 4'hF) begin failures++; $display("FAIL rd_wait_state got=%b/%b exp=0/1111", master_read, req_waitrequest); end
        next_cycle(); #1;
        checks++; if (req_readdatavalid !== 4'b0000) begin failures++; $display("FAIL rd_early_rdv got=%b exp=0000", req_readdatavalid); end
        next_cycle();
        master_readdatavalid = 1'b1;
        master_readdata      = 32'hFFFF_FFFB;
        #1;
        checks++; if (req_readdatavalid !== 4'b0001) begin failures++; $display("FAIL rd_rdv got=%b exp=0001", req_readdatavalid); end
        checks++; if (req_readdata !== 32'hFFFF_FFFB) begin failures++; $display("FAIL rd_data got=%h exp=fffffffb", req_readdata); end
        next_cycle();
        master_readdatavalid = 1'b0;
        #1;
        checks++; if (req_readdatavalid !== 4'b0000) begin failures++; $display("FAIL rd_rdv_one_cycle got=%b exp=0000", req_readdatavalid); end
        next_cycle(); #1;
        checks++; if (grant !== 4'b0000 || err_spurious !== 1'b0) begin failures++; $display("FAIL rd_release got=%b/%b exp=0000/0", grant, err_spurious); end
    endtask

    task automatic test_round_robin_writes;
        int got[$];
        int o;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_address[i*AW +: AW]   = 32'h200 + 32'(i);
            req_writedata[i*DW +: DW] = 32'hA0 + 32'(i);
        end
        req_write          = 4'b1011;
        master_waitrequest = 1'b0;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            next_cycle(); #1;
            checks++; if ($countones(grant) > 1) begin failures++; $display("FAIL rr_onehot got=%b exp=at most one bit", grant); end
            if (master_write) begin
                o = owner_idx(grant);
                got.push_back(o);
                checks++; if (master_writedata !== 32'hA0 + 32'(o)) begin failures++; $display("FAIL rr_wdata got=%h exp=%h", master_writedata, 32'hA0 + 32'(o)); end
            end
        end
        req_write = '0;
        checks++; if (got.size() != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", got.size()); end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            checks++; if (got[k] != exp_rr[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, got[k], exp_rr[k]); end
        end
        next_cycle(); next_cycle(); next_cycle();
    endtask

    task automatic test_read_with_waiter;
        apply_reset();
        req_read           = 4'b0100;
        master_waitrequest = 1'b0;
        next_cycle();
        req_write = 4'b0010;
        #1;
        checks++; if (grant !== 4'b0100 || req_waitrequest !== 4'b1011) begin failures++; $display("FAIL rw_xfer got=%b/%b exp=0100/1011", grant, req_waitrequest); end
        next_cycle();
        req_read = 4'b0000;
        #1;
        checks++; if (req_waitrequest !== 4'hF) begin failures++; $display("FAIL rw_rdwait_wr got=%b exp=1111", req_waitrequest); end
        next_cycle();
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h1234_5678;
        #1;
        checks++; if (req_readdatavalid !== 4'b0100 || req_readdata !== 32'h1234_5678) begin failures++; $display("FAIL rw_rdv got=%b/%h exp=0100/12345678", req_readdatavalid, req_readdata); end
        checks++; if (req_waitrequest[1] !== 1'b1) begin failures++; $display("FAIL rw_waiter_rd got=%b exp=1", req_waitrequest[1]); end
        next_cycle();
        master_readdatavalid = 1'b0;
        #1;
        checks++; if (req_waitrequest[1] !== 1'b1 || grant !== 4'b0100) begin failures++; $display("FAIL rw_release got=%b/%b exp=1/0100", req_waitrequest[1], grant); end
        next_cycle(); #1;
        checks++; if (grant !== 4'b0000 || req_waitrequest[1] !== 1'b1) begin failures++; $display("FAIL rw_idle got=%b/%b exp=0000/1", grant, req_waitrequest[1]); end
        next_cycle(); #1;
        checks++; if (grant !== 4'b0010 || req_waitrequest !== 4'b1101 || master_write !== 1'b1) begin failures++; $display("FAIL rw_waiter_xfer got=%b/%b/%b exp=0010/1101/1", grant, req_waitrequest, master_write); end
        next_cycle();
        req_write = '0;
        next_cycle(); next_cycle(); #1;
        checks++; if (err_spurious !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL rw_end got=%b/%b exp=0/0000", err_spurious, grant); end
    endtask

    task automatic test_reset_in_rd_wait;
        apply_reset();
        req_read           = 4'b0001;
        master_waitrequest = 1'b0;
        next_cycle();
        next_cycle();
        req_read = 4'b0000;
        rst      = 1'b1;
        next_cycle();
        rst                  = 1'b0;
        master_readdatavalid = 1'b1;
        master_readdata      = 32'hDEAD_BEEF;
        #1;
        checks++; if (req_readdatavalid !== 4'b0000) begin failures++; $display("FAIL rst_late_rdv got=%b exp=0000", req_readdatavalid); end
        next_cycle();
        master_readdatavalid = 1'b0;
        #1;
        checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL rst_spurious got=%b exp=1", err_spurious); end
        checks++; if (grant !== 4'b0000 || master_read !== 1'b0 || master_write !== 1'b0 || master_address !== 32'h0) begin failures++; $display("FAIL rst_outputs got=%b/%b/%b/%h exp=0000/0/0/0", grant, master_read, master_write, master_address); end
        checks++; if (req_waitrequest !== 4'hF || req_readdatavalid !== 4'b0000) begin failures++; $display("FAIL rst_req_side got=%b/%b exp=1111/0000", req_waitrequest, req_readdatavalid); end
    endtask

    task automatic test_lock_stream;
        int got[$];
        int n1;
        int target;
`ifdef ARB_LOCK_EN
        target = 65;
`else
        target = 4;
`endif
        n1 = 0;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_writedata[i*DW +: DW] = 32'hC0 + 32'(i);
        end
        req_write          = 4'b0010;
        req_lock           = 4'b0010;
        master_waitrequest = 1'b0;
        for (int c = 0; c < 400 && got.size() < target; c++) begin
            next_cycle(); #1;
            if (master_write) begin
                got.push_back(owner_idx(grant));
                if (owner_idx(grant) == 1) begin
                    n1++;
                    if (n1 == 64) req_lock = 4'b0000;
                end
            end
            if (c == 0) req_write = 4'b0011;
        end
        req_write = '0;
        req_lock  = '0;
        checks++; if (got.size() != target) begin failures++; $display("FAIL lock_count got=%0d exp=%0d", got.size(), target); end
`ifdef ARB_LOCK_EN
        for (int k = 0; k < got.size() && k < 64; k++) begin
            checks++; if (got[k] != 1) begin failures++; $display("FAIL lock_hold[%0d] got=%0d exp=1", k, got[k]); end
        end
        if (got.size() == 65) begin
            checks++; if (got[64] != 0) begin failures++; $display("FAIL lock_after got=%0d exp=0", got[64]); end
        end
`else
        for (int k = 0; k < got.size() && k < 4; k++) begin
            checks++; if (got[k] != ((k % 2 == 0) ? 1 : 0)) begin failures++; $display("FAIL nolock_alt[%0d] got=%0d exp=%0d", k, got[k], (k % 2 == 0) ? 1 : 0); end
        end
`endif
        next_cycle(); next_cycle(); next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin_writes();
        test_read_with_waiter();
        test_reset_in_rd_wait();
        test_lock_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
